shift_frame_serializer: RTL and testbench

Upstream feeder for the bidirectional shift register. Accepts a parallel word plus a direction flag over a valid/ready handshake and replays it as a serial bit stream on `d`, with matching `en` and `dir` strobes. Bit order is chosen so the downstream register holds exactly the accepted word after the last shift. A one-cycle `done` pulse marks frame completion, and a programmable idle gap separates frames.

---
 rtl/shift_frame_serializer_if.sv | 28 ++
 rtl/shift_frame_serializer.sv | 139 +++++++++++++
 tb/tb_shift_frame_serializer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_serializer_if.sv
// Upstream frame handshake for shift_frame_serializer.
//   in_valid : producer has a frame on in_data/in_dir
//   in_ready : serializer can accept a frame this cycle
//   in_data  : parallel word, MSB bits wide
//   in_dir   : shift direction for the frame (0 = left, 1 = right)
// master = frame producer, slave = serializer.
interface shift_frame_serializer_if #(
  parameter int MSB = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [MSB-1:0] in_data;
  logic           in_dir;

  modport master (
    output in_valid,
    output in_data,
    output in_dir,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dir,
    output in_ready
  );
endinterface

// File: rtl/shift_frame_serializer.sv
// Feeder for the bidirectional shift register: accepts a parallel word and a
// direction over a valid/ready handshake and replays it serially on d with
// matching en/dir strobes. Left frames go MSB first and right frames go LSB
// first, so the downstream register holds the accepted word after the last
// shift. done pulses once per frame, followed by GAP idle cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   up   : frame handshake (in_valid/in_ready/in_data/in_dir), slave side
//   d    : serial bit (0 whenever en is 0)
//   en   : downstream shift enable
//   dir  : latched frame direction
//   busy : high from the cycle after accept through the last gap cycle
//   done : one-cycle pulse after the last bit
module shift_frame_serializer #(
  parameter int MSB = 4,
  parameter int GAP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  shift_frame_serializer_if.slave  up,
  output logic                     d,
  output logic                     en,
  output logic                     dir,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(MSB + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int IW = $clog2(MSB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [GW-1:0]  gcnt, gcnt_n;
  logic [MSB-1:0] shadow, shadow_n;
  logic           dir_n, d_n, en_n, done_n, busy_n;
  logic [IW-1:0]  idx;

  assign up.in_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      shadow <= '0;
      dir    <= 1'b0;
      d      <= 1'b0;
      en     <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gcnt   <= gcnt_n;
      shadow <= shadow_n;
      dir    <= dir_n;
      d      <= d_n;
      en     <= en_n;
      done   <= done_n;
      busy   <= busy_n;
    end
  end

  // Outputs are registered, so each state computes the value for the next
  // cycle: the first bit is presented straight from in_data on the accept
  // edge, later bits are picked from the shadow using the decremented count.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    shadow_n = shadow;
    dir_n    = dir;
    d_n      = 1'b0;
    en_n     = 1'b0;
    done_n   = 1'b0;
    busy_n   = busy;
    idx      = '0;

    unique case (state)
      S_IDLE: begin
        if (up.in_valid) begin
          state_n  = S_SHIFT;
          cnt_n    = CW'(MSB);
          shadow_n = up.in_data;
          dir_n    = up.in_dir;
          en_n     = 1'b1;
          d_n      = up.in_dir ? up.in_data[0] : up.in_data[MSB-1];
          busy_n   = 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt == CW'(1)) begin
          state_n = S_DONE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
          en_n  = 1'b1;
          // count k presents bit k-1 (left) or bit MSB-k (right)
          idx   = dir ? IW'(MSB - int'(cnt_n)) : IW'(int'(cnt_n) - 1);
          d_n   = shadow[idx];
        end
      end

      S_DONE: begin
        if (GAP > 0) begin
          state_n = S_GAP;
          gcnt_n  = GW'(GAP);
        end else begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end
      end

      S_GAP: begin
        if (gcnt == GW'(1)) begin
          state_n = S_IDLE;
          gcnt_n  = '0;
          busy_n  = 1'b0;
        end else begin
          gcnt_n = gcnt - GW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_frame_serializer.sv
module tb_shift_frame_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_frame_serializer_if #(.MSB(4)) if_a ();
  shift_frame_serializer_if #(.MSB(4)) if_b ();
  shift_frame_serializer_if #(.MSB(8)) if_c ();

  logic d_a, en_a, dir_a, busy_a, done_a;
  logic d_b, en_b, dir_b, busy_b, done_b;
  logic d_c, en_c, dir_c, busy_c, done_c;

  shift_frame_serializer #(.MSB(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .up(if_a.slave),
    .d(d_a), .en(en_a), .dir(dir_a), .busy(busy_a), .done(done_a)
  );
  shift_frame_serializer #(.MSB(4), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .up(if_b.slave),
    .d(d_b), .en(en_b), .dir(dir_b), .busy(busy_b), .done(done_b)
  );
  shift_frame_serializer #(.MSB(8), .GAP(3)) u_c (
    .clk(clk), .rst(rst), .up(if_c.slave),
    .d(d_c), .en(en_c), .dir(dir_c), .busy(busy_c), .done(done_c)
  );

  // downstream bidirectional shift registers: dir 0 shifts left (d into
  // LSB), dir 1 shifts right (d into MSB)
  logic [3:0] out_a = '0, out_b = '0;
  logic [7:0] out_c = '0;
  always @(posedge clk) if (en_a) out_a <= dir_a ? {d_a, out_a[3:1]} : {out_a[2:0], d_a};
  always @(posedge clk) if (en_b) out_b <= dir_b ? {d_b, out_b[3:1]} : {out_b[2:0], d_b};
  always @(posedge clk) if (en_c) out_c <= dir_c ? {d_c, out_c[7:1]} : {out_c[6:0], d_c};

  logic       exp_q[$];
  logic [3:0] word_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic test_reset();
    rst = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_dir = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_dir = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.in_dir = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({d_a, en_a, dir_a, busy_a, done_a, if_a.in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_a: got %b want 000001", {d_a, en_a, dir_a, busy_a, done_a, if_a.in_ready});
    end
    n_checks++;
    if ({en_c, busy_c, done_c, if_c.in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_c: got %b want 0001", {en_c, busy_c, done_c, if_c.in_ready});
    end
    // a valid request while reset is high must not be taken
    if_a.in_valid = 1'b1; if_a.in_data = 4'hF;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({en_a, busy_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_accept: en/busy got %b want 00", {en_a, busy_a});
    end
    if_a.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_frame_a(input logic [3:0] data, input logic fdir, input logic corrupt);
    logic b;
    @(negedge clk);
    n_checks++;
    if (if_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_ready_pre: got %b want 1", if_a.in_ready);
    end
    if_a.in_valid = 1'b1; if_a.in_data = data; if_a.in_dir = fdir;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(fdir ? data[i] : data[3-i]);
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
    if_a.in_data  = corrupt ? 4'hF : ~data;
    if_a.in_dir   = ~fdir;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({en_a, done_a, dir_a, busy_a} !== {1'b1, 1'b0, fdir, 1'b1}) begin
        n_fail++;
        $display("FAIL shift_ctl c%0d: en,done,dir,busy got %b want %b", c,
                 {en_a, done_a, dir_a, busy_a}, {1'b1, 1'b0, fdir, 1'b1});
      end
      b = exp_q.pop_front();
      n_checks++;
      if (d_a !== b) begin
        n_fail++;
        $display("FAIL shift_bit c%0d data %h dir %b: got %b want %b", c, data, fdir, d_a, b);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({done_a, en_a, d_a, if_a.in_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL done_cycle: done,en,d,ready got %b want 1000", {done_a, en_a, d_a, if_a.in_ready});
    end
    n_checks++;
    if (out_a !== data) begin
      n_fail++;
      $display("FAIL downstream_out: got %h want %h", out_a, data);
    end
    @(negedge clk);
    n_checks++;
    if ({done_a, busy_a, if_a.in_ready, dir_a} !== {3'b010, fdir}) begin
      n_fail++;
      $display("FAIL gap_cycle: done,busy,ready,dir got %b want %b", {done_a, busy_a, if_a.in_ready, dir_a}, {3'b010, fdir});
    end
    @(negedge clk);
    n_checks++;
    if ({if_a.in_ready, busy_a, dir_a} !== {2'b10, fdir}) begin
      n_fail++;
      $display("FAIL idle_return: ready,busy,dir got %b want %b", {if_a.in_ready, busy_a, dir_a}, {2'b10, fdir});
    end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    @(negedge clk);
    if_a.in_valid = 1'b1; if_a.in_data = 4'h9; if_a.in_dir = 1'b0;
    @(posedge clk);
    #1 if_a.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({en_a, busy_a, done_a, if_a.in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_async: en,busy,done,ready got %b want 0001", {en_a, busy_a, done_a, if_a.in_ready});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_a || en_a) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: activity got %b want 0", seen_done);
    end
    n_checks++;
    if (if_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b want 1", if_a.in_ready);
    end
    test_frame_a(4'h6, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int last_acc = -1;
    int accepts = 0;
    int dones = 0;
    logic b;
    logic [3:0] w;
    bit acc;
    exp_q.delete(); word_q.delete();
    @(negedge clk);
    if_b.in_valid = 1'b1; if_b.in_data = 4'hA; if_b.in_dir = 1'b0;
    for (int cyc = 0; cyc < 60 && dones < 4; cyc++) begin
      acc = 1'b0;
      if (en_b) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_bit cyc%0d: got en=1 want no bit", cyc);
        end else begin
          b = exp_q.pop_front();
          if (d_b !== b) begin
            n_fail++;
            $display("FAIL b2b_bit cyc%0d: got %b want %b", cyc, d_b, b);
          end
        end
      end
      if (done_b) begin
        dones++;
        w = (word_q.size() > 0) ? word_q.pop_front() : 4'hx;
        n_checks++;
        if (out_b !== w) begin
          n_fail++;
          $display("FAIL b2b_done_word %0d: got %h want %h", dones, out_b, w);
        end
      end
      if (if_b.in_ready && if_b.in_valid) begin
        acc = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(if_b.in_data[3-i]);
        word_q.push_back(if_b.in_data);
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 6) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d want 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if_b.in_data = (if_b.in_data == 4'hA) ? 4'h5 : 4'hA;
        if (accepts == 4) if_b.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (dones != 4 || accepts != 4) begin
      n_fail++;
      $display("FAIL b2b_count: dones %0d accepts %0d want 4 4", dones, accepts);
    end
  endtask

  task automatic test_wide();
    int en_cnt = 0;
    int done_cnt = 0;
    int low_after = 0;
    logic b;
    logic [7:0] data = 8'hC3;
    exp_q.delete();
    @(negedge clk);
    if_c.in_valid = 1'b1; if_c.in_data = data; if_c.in_dir = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(data[7-i]);
    @(posedge clk);
    #1 if_c.in_valid = 1'b0; if_c.in_data = 8'h00;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (en_c) begin
        en_cnt++;
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        n_checks++;
        if (d_c !== b) begin
          n_fail++;
          $display("FAIL wide_bit %0d: got %b want %b", en_cnt, d_c, b);
        end
      end
      if (done_c) begin
        done_cnt++;
        n_checks++;
        if (out_c !== data) begin
          n_fail++;
          $display("FAIL wide_out: got %h want %h", out_c, data);
        end
      end else if (done_cnt > 0) begin
        if (!if_c.in_ready) low_after++;
        else break;
      end
    end
    n_checks++;
    if (en_cnt != 8 || done_cnt != 1 || low_after != 3) begin
      n_fail++;
      $display("FAIL wide_timing: en %0d done %0d gap %0d want 8 1 3", en_cnt, done_cnt, low_after);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_a(4'b1011, 1'b0, 1'b0);
    test_frame_a(4'b1011, 1'b1, 1'b0);
    test_frame_a(4'h3, 1'b0, 1'b1);
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
